rx_mod: RTL and testbench
=========================

Name: rx_mod

Overview:
UART serial receiver. It converts an asynchronous 8N1-style bit stream on i_rx into a parallel word, using the oversampling tick i_s_tick at 16 ticks per bit from the shared baud generator. It sits between the pad-side RX line and the UART interface/FIFO logic, and reports each received word with a one-cycle done pulse.

Parameters:
NB_DATA, 8, number of data bits per frame, sent LSB first.
STOP_TICKS, 16, oversampling ticks spent in the stop bit: 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_reset  input  1  synchronous, active-high reset.
i_s_tick  input  1  oversampling enable: one-clock pulse, 16 per bit period.
i_rx  input  1  serial line; idle high.
o_rx_data  output  NB_DATA  last received word.
o_rx_done_tick  output  1  one-clock pulse when o_rx_data is valid.

Behaviour:
- Interface: one clock, i_clk; reset i_reset is synchronous and active-high.
- i_rx passes through a 2-flop synchronizer, reset to 1; the FSM uses only the synchronized value rx_s.
- Reset: state=IDLE, tick counter s=0, bit counter n=0, shift register=0, o_rx_data=0, o_rx_done_tick=0.
- Reset asserted mid-frame aborts the frame; no done pulse is produced.
- s is wide enough for max(15, STOP_TICKS-1). n is clog2(NB_DATA) bits.
- Ticks advance state only in cycles with i_s_tick=1.
- IDLE:
  - rx_s==0 -> START, s=0. Start detection is level-based and needs no tick.
- START:
  - On each tick, if s==7 (mid start bit): rx_s==0 -> DATA with s=0, n=0. rx_s==1 -> IDLE (glitch rejected, no output).
  - Otherwise s++.
- DATA:
  - On each tick, if s==15: s=0 and shift right with rx_s entering the MSB.
  - If n==NB_DATA-1 -> STOP, else n++.
  - Otherwise s++.
  - Effect: each bit is sampled at mid-bit, and the first data bit lands in the LSB.
- STOP:
  - On each tick, if s==STOP_TICKS-1 -> IDLE.
  - If rx_s==1 at that point: o_rx_data <= shift register, and o_rx_done_tick=1 on the next clock only.
  - If rx_s==0 (framing error): frame is discarded, o_rx_data keeps its old value, no pulse.
  - Otherwise s++.
- o_rx_done_tick is registered and exactly one i_clk wide, regardless of tick spacing.
- o_rx_data holds its value until the next good frame completes.
- Back-to-back frames: from IDLE entered on the final stop tick, a low line is detected on the next clock.
- Line held low after a framing error: the receiver re-enters START immediately and resynchronizes on subsequent edges.
- Latency: done pulse is about 7 + 16*NB_DATA + STOP_TICKS ticks after start detection, plus 1 clock.
- i_s_tick held continuously high is legal; counting then runs at the clock rate.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, DATA, STOP), the oversample constant 16, and the mid-start constant 7.
- One natural sub-module, sync_2ff, for the i_rx synchronizer.
- FSM and datapath stay in rx_mod.

Test Plan:
- Reset, then send 0x55 framed 0/bits LSB-first/1, 16 ticks per bit (tick every 3 clocks) -> exactly one o_rx_done_tick, o_rx_data=0x55 in that cycle.
- Back-to-back 0xAA, 0x00, 0xFF with no idle gap -> three single-cycle pulses; data 0xAA, 0x00, 0xFF in order.
- Low glitch on i_rx lasting 4 ticks from idle -> returns to IDLE; no pulse; o_rx_data unchanged; a following 0x3C is received correctly.
- Frame 0xA5 with stop bit held low -> no pulse, o_rx_data keeps its previous value; the next valid frame 0x5A is received.
- Assert i_reset for 1 clock after the 4th data bit -> o_rx_data=0, no pulse; a subsequent 0xC3 is received correctly.
- STOP_TICKS=32, send 0x81 -> pulse occurs 16 ticks later than with the default, o_rx_data=0x81.

Source files
------------

// File: rtl/rx_mod_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, oversampling
// constants and a helper that sizes the oversampling tick counter.
package rx_mod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

  // The tick counter must reach both OVERSAMPLE-1 and STOP_TICKS-1.
  function automatic int tick_cnt_width(input int stop_ticks);
    int top;
    top = (stop_ticks > OVERSAMPLE) ? stop_ticks : OVERSAMPLE;
    return (top <= 2) ? 1 : $clog2(top);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous RX pad into the i_clk domain.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/rx_mod.sv
// UART 8N1-style receiver: 16x oversampled, mid-bit sampling, LSB first,
// one-clock done pulse per good frame; frames with a low stop bit are dropped.
module rx_mod
  import rx_mod_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done_tick
);

  localparam int S_W = tick_cnt_width(STOP_TICKS);
  localparam int N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [S_W-1:0] S_MID      = S_W'(MID_START);
  localparam logic [S_W-1:0] S_BIT_END  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_END = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(NB_DATA - 1);

  rx_state_e          state_q, state_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_rx),
    .o_q    (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Level-based start detection, independent of the tick.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d     = '0;
            shift_d = {rx_s, shift_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_q == S_STOP_END) begin
            state_d = IDLE;
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_rx_data      = data_q;
    o_rx_done_tick = done_q;
  end

endmodule

// File: tb/tb_rx_mod.sv
// Directed and randomized frames into two receivers (1 and 2 stop bits),
// checked against a frame-level model of which words should arrive.
module tb_rx_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx32;
  logic [7:0] data16, data32;
  logic       done16, done32;

  always #5 clk = ~clk;

  rx_mod #(.NB_DATA(8), .STOP_TICKS(16)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_s_tick      (s_tick),
    .i_rx          (rx),
    .o_rx_data     (data16),
    .o_rx_done_tick(done16)
  );

  rx_mod #(.NB_DATA(8), .STOP_TICKS(32)) dut32 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_s_tick      (s_tick),
    .i_rx          (rx32),
    .o_rx_data     (data32),
    .o_rx_done_tick(done32)
  );

  int         period    = 3;
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  bit         drive32   = 1'b0;
  logic [7:0] got16_q[$];
  logic [7:0] got32_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_last  = 8'h00;
  longint     cyc       = 0;
  longint     done_cyc16 = 0;
  longint     done_cyc32 = 0;
  bit         prev16 = 1'b0, prev32 = 1'b0, wide_seen = 1'b0;

  // Output monitor: collects every done pulse and flags any pulse wider than one clock.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done16) begin
      got16_q.push_back(data16);
      done_cyc16 = cyc;
      if (prev16) wide_seen = 1'b1;
    end
    if (done32) begin
      got32_q.push_back(data32);
      done_cyc32 = cyc;
      if (prev32) wide_seen = 1'b1;
    end
    prev16 = done16;
    prev32 = done32;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One tick slot: tick high for the first clock, then low for period-1 clocks.
  task automatic tick_once();
    s_tick = 1'b1;
    @(negedge clk);
    if (period > 1) begin
      s_tick = 1'b0;
      repeat (period - 1) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic v, input int nticks);
    rx = v;
    if (drive32) rx32 = v;
    repeat (nticks) tick_once();
  endtask

  // Stimulus plus model: a frame with a high stop bit yields its byte, otherwise nothing.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_stop);
    send_bits(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bits(b[i], 16);
    if (stop_ok) begin
      send_bits(1'b1, 16 + extra_stop);
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      send_bits(1'b0, 12);
      send_bits(1'b1, 4 + 16);
    end
  endtask

  task automatic check_frames(input string tag);
    int n;
    repeat (4) tick_once();
    check({tag, "_count"}, got16_q.size(), exp_q.size());
    n = (got16_q.size() < exp_q.size()) ? got16_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", tag, i), {24'd0, got16_q[i]}, {24'd0, exp_q[i]});
    check({tag, "_hold"}, {24'd0, data16}, {24'd0, exp_last});
    check({tag, "_width"}, {31'd0, wide_seen}, 32'd0);
    $display("%s: %0d word(s) expected, %0d received, o_rx_data=0x%02h", tag,
             exp_q.size(), got16_q.size(), data16);
    got16_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         periods[4];
    periods = '{1, 2, 3, 5};
    s_tick = 1'b0;
    rx     = 1'b1;
    rx32   = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_data", {24'd0, data16}, 32'd0);
    check("rst_done", {31'd0, done16}, 32'd0);
    check("rst_data32", {24'd0, data32}, 32'd0);

    send_frame(8'h55, 1'b1, 0);
    check_frames("f55");

    send_frame(8'hAA, 1'b1, 0);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    check_frames("b2b");

    send_bits(1'b0, 4);
    send_bits(1'b1, 24);
    check_frames("glitch");
    send_frame(8'h3C, 1'b1, 0);
    check_frames("f3c");

    send_frame(8'hA5, 1'b0, 0);
    check_frames("ferr");
    send_frame(8'h5A, 1'b1, 0);
    check_frames("f5a");

    // Abort a frame after its 4th data bit with a one-clock reset.
    send_bits(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bits(i[0], 16);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_last = 8'h00;
    send_bits(1'b1, 32);
    check_frames("midrst");
    send_frame(8'hC3, 1'b1, 0);
    check_frames("fc3");

    // Same frame into both receivers; the 2-stop-bit one finishes 16 ticks later.
    got32_q.delete();
    drive32 = 1'b1;
    send_frame(8'h81, 1'b1, 16);
    drive32 = 1'b0;
    check_frames("f81");
    check("st32_count", got32_q.size(), 32'd1);
    if (got32_q.size() > 0) check("st32_word", {24'd0, got32_q[0]}, 32'h81);
    check("st32_delay", 32'(done_cyc32 - done_cyc16), 32'(16 * period));
    $display("st32: done16 at cycle %0d, done32 at cycle %0d", done_cyc16, done_cyc32);

    for (int k = 0; k < 8; k++) begin
      period = periods[$urandom_range(0, 3)];
      b = 8'($urandom);
      send_frame(b, ($urandom_range(0, 3) != 0), 16 * $urandom_range(0, 1));
      check_frames($sformatf("rnd%0d_p%0d", k, period));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
